// File: rtl/mult_seq_ctrl_if.sv
// Operand/result bundle between the ALU multiply issue logic and mult_seq_ctrl.
// The master drives start and operands; the slave returns status and the product.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input product);
    modport slave  (input  start, input  a,    input b,
                    output busy,  output done, output product);
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-add sequencer for the ALU multiplier: one add/shift per cycle over a
// combined hi:lo product register, WIDTH iterations, then a one-cycle done pulse.
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;

    // The carry out of the hi add is kept and shifted into the top bit.
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        prod  <= {{WIDTH{1'b0}}, bus.b};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    prod <= {sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = prod;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: reset, latency, operand corner cases,
// ignored starts and back-to-back issue, with hand-computed products.
module tb_mult_seq_ctrl;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    mult_seq_ctrl_if #(.WIDTH(32)) bus ();

    mult_seq_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands with start high for one edge; returns 1ns after the accept edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        vectors++;
        if (bus.product !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_product got %h want %h", bus.product, 64'd0);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        #11;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_latency();
        int busy_bad;
        busy_bad = 0;
        start_op(32'd6, 32'd7);
        for (int i = 0; i < 32; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL basic_busy_window got %0d bad cycles want 0", busy_bad);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_cycle got busy=%b done=%b want 0 1", bus.busy, bus.done);
        end
        vectors++;
        if (bus.product !== 64'd42) begin
            miscompares++;
            $display("FAIL basic_product got %h want %h", bus.product, 64'd42);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_single got done=%b want 0", bus.done);
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (bus.product !== 64'd42 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hold got %h busy=%b want %h busy=0", bus.product, bus.busy, 64'd42);
        end
    endtask

    task automatic test_max_operands();
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.product !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL max_product got %h done=%b want %h done=1",
                     bus.product, bus.done, 64'hFFFF_FFFE_0000_0001);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_identity();
        start_op(32'd0, 32'h1234_5678);
        repeat (31) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_full_latency got busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.product !== 64'd0) begin
            miscompares++;
            $display("FAIL zero_product got %h done=%b want 0 done=1", bus.product, bus.done);
        end
        @(posedge clk);
        #1;
        start_op(32'd1, 32'h8000_0000);
        repeat (32) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.product !== 64'h0000_0000_8000_0000) begin
            miscompares++;
            $display("FAIL identity_product got %h done=%b want %h done=1",
                     bus.product, bus.done, 64'h0000_0000_8000_0000);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignored_start_back_to_back();
        start_op(32'd2, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.product !== 64'd6) begin
            miscompares++;
            $display("FAIL ignore_run_product got %h done=%b want %h done=1", bus.product, bus.done, 64'd6);
        end
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd6) begin
            miscompares++;
            $display("FAIL ignore_done got %h busy=%b done=%b want %h busy=0 done=0",
                     bus.product, bus.busy, bus.done, 64'd6);
        end
        bus.a = 32'd10;
        bus.b = 32'd10;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept got busy=%b want 1", bus.busy);
        end
        repeat (32) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.product !== 64'd100) begin
            miscompares++;
            $display("FAIL b2b_product got %h done=%b want %h done=1", bus.product, bus.done, 64'd100);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_gap got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_reaccept got busy=%b want 1", bus.busy);
        end
        repeat (33) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        start_op(32'd5, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.product !== 64'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async got %h busy=%b done=%b want 0 0 0",
                     bus.product, bus.busy, bus.done);
        end
        #2;
        reset_n = 1'b1;
        start_op(32'd3, 32'd4);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_first_accept got busy=%b want 1", bus.busy);
        end
        repeat (32) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.product !== 64'd12) begin
            miscompares++;
            $display("FAIL midreset_product got %h done=%b want %h done=1", bus.product, bus.done, 64'd12);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_latency();
        test_max_operands();
        test_zero_identity();
        test_ignored_start_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

- Sequencing controller for the ALU's 32-bit shift-add multiplier.
- Accepts operands on a start pulse and runs exactly WIDTH add/shift iterations over the product register.
- Signals completion with a one-cycle done pulse and holds the 2·WIDTH-bit product until the next accepted start.
- Sits beside the combinational ALU slices; the ALU result mux selects `product` for multiply ops.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2·WIDTH bits; iteration count = WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand, unsigned, captured on accept.
- b  in  WIDTH  multiplier, unsigned, captured on accept.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse, high in DONE.
- product  out  2·WIDTH  product register (hi:lo), held after DONE.

## Operation
- Internal state:
  - mcand: WIDTH-bit register.
  - prod: 2·WIDTH-bit register, hi = [2W-1:W], lo = [W-1:0].
  - cnt: counter, $clog2(WIDTH) bits.
  - state: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at an edge: mcand←a, prod←{0, b}, cnt←0, go to RUN.
  - With start=0: stay in IDLE; prod holds.
- RUN, one iteration per edge:
  - sum = {1'b0, hi} + (prod[0] ? {1'b0, mcand} : 0), 33 bits (WIDTH+1), carry kept.
  - prod←{sum, lo} >> 1, i.e. {sum[W:0], lo[W-1:1]}.
  - cnt←cnt+1.
  - On the edge where cnt==WIDTH-1: perform the final iteration, go to DONE.
- DONE:
  - done=1 for exactly one cycle; prod holds.
  - Unconditionally go to IDLE on the next edge.
- start while in RUN or DONE is ignored; no queuing. The a and b inputs are ignored after capture.
- Arithmetic is unsigned. Result = a·b exactly; no overflow is possible in 2·WIDTH bits.
- `product` is driven directly from prod.
  - During RUN it shows partial values and is not valid.
  - It is valid from DONE until the next accepted start.

## Timing
- Reset (async, any time including mid-RUN):
  - state=IDLE, busy=0, done=0, product=0, mcand=0, cnt=0.
  - The operation in flight is discarded.
  - The first start is accepted on the first rising edge with reset_n=1.
- Accept at edge E0 (IDLE, start=1):
  - busy=1 from E0 through E0+32; the WIDTH iterations happen on edges E0+1 … E0+WIDTH.
  - State enters DONE at E0+WIDTH.
  - done=1 in the cycle between E0+WIDTH and E0+WIDTH+1; busy=0 in that cycle.
  - Latency is WIDTH+1 edges from accept to done, counting the accept edge.
- Back-to-back: start held continuously is accepted again at E0+WIDTH+2, the first edge in IDLE. Minimum issue interval is WIDTH+2 cycles.
- busy and done are never high together. done is never high for two consecutive cycles.
- b=0 or a=0 still takes the full WIDTH iterations; there is no early termination.

## Test plan
- Reset mid-op:
  - Stimulus: accept a=5, b=7; assert reset_n=0 at iteration 10.
  - Required: product=0, busy=0, done=0 immediately, without waiting for a clock edge.
  - After release: a=3, b=4 → product=12.
- Basic latency:
  - Stimulus: a=6, b=7 accepted at E0.
  - Required: busy high for 32 cycles; done pulses exactly once, in the cycle after E0+32; product=42, held until the next start.
- Max operands:
  - Stimulus: a=b=32'hFFFFFFFF.
  - Required: product=64'hFFFFFFFE00000001; checks the carry into hi on every iteration.
- Zero and identity:
  - a=0, b=32'h12345678 → product=0, same full latency.
  - a=1, b=32'h80000000 → product=64'h0000000080000000.
- Ignored start and back-to-back:
  - Stimulus: accept a=2, b=3; pulse start with a=9, b=9 during RUN and during DONE.
  - Required: product=6; no second operation starts.
  - Then hold start=1 with a=10, b=10: accepted at E0+34, and the second done shows product=100.
